ldm_stm_sequencer: RTL
======================

# ldm_stm_sequencer

Multi-cycle controller for LDM/STM block transfers in the 5-stage pipelined core.
- When decode holds a valid block-transfer instruction, the sequencer freezes fetch and decode.
- It then issues one single-register load/store micro-op per register-list bit into the execute stage, plus an optional base write-back micro-op.
- It sits between decode and the main control/hazard logic. Its micro-op outputs override the RegSrc/Rd/immediate selection of the datapath for the sequence's duration.

## Interface
Parameters:
- OFFSET_W, 32, width of the sign-extended byte offset driven to the immediate path.

Ports:
- clk  in  1  core clock; one clock for the whole block.
- reset  in  1  synchronous, active-high; returns the FSM to IDLE.
- InstrD  in  32  decode-stage instruction. Fields used: P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0].
- BlockValidD  in  1  InstrD is a block transfer, condition passed, not flushed.
- HoldIn  in  1  external stall from the hazard unit; freezes the sequencer.
- Kill  in  1  abort the current sequence (branch taken / flush of the owning instruction).
- StallF  out  1  1 = hold the PC register.
- StallD  out  1  1 = hold the Fetch→Decode register.
- Busy  out  1  FSM not IDLE.
- UopValid  out  1  a micro-op is presented this cycle.
- UopLoad  out  1  1 = load (LDR-like), 0 = store; undefined for write-back.
- UopWB  out  1  micro-op is the base write-back (Rn ← Rn + UopOffset).
- UopRd  out  4  transfer register, or Rn for write-back.
- UopRn  out  4  base register.
- UopOffset  out  OFFSET_W  two's-complement byte offset from the original Rn.

## Operation
- FSM states: IDLE, XFER, WBACK.
- Start condition: IDLE & BlockValidD & ~HoldIn & ~Kill & list≠0. On start:
  - Latch list→Mask, Rn, L, W, U, and Base.
  - Base = U ? (P ? 4 : 0) : (P ? −4n : −4(n−1)), where n = popcount(list).
  - Clear the issue index k; go to XFER.
- list==0: no-op. Stay in IDLE, no stall, no micro-op.
- XFER: each advancing cycle (~HoldIn):
  - UopValid=1, UopRd = index of the lowest set bit of Mask, UopOffset = Base + 4k.
  - Clear that bit and increment k.
  - When the issued bit is the last one: go to WBACK if W & ~(L & list[Rn]); otherwise go to IDLE.
- WBACK: UopValid=1, UopWB=1, UopRd=Rn, UopOffset = U ? +4n : −4n. Then go to IDLE.
- Base in list with L=1 and W=1: the loaded value wins and the write-back micro-op is suppressed. STM with Rn in the list stores the original Rn (datapath reads Rn before the write-back).
- HoldIn=1 while Busy: UopValid=0, and Mask/k/state are frozen. StallF/StallD stay at 1.
- Kill=1: go to IDLE next cycle. UopValid=0 in the Kill cycle, and no further micro-ops are issued.
- Kill has priority over HoldIn, and HoldIn has priority over advance.
- Arithmetic: all offsets are computed at OFFSET_W bits, two's complement. n ≤ 16, so |offset| ≤ 64.

## Timing
- Reset values: state IDLE, Mask 0, k 0. Outputs StallF=0, StallD=0, Busy=0, UopValid=0, UopWB=0, UopLoad=0, UopRd=0, UopRn=0, UopOffset=0.
- Cycle 0 (start cycle): no micro-op. StallF=StallD=1 combinationally from the start condition.
- Cycles 1..n: transfer micro-ops, one per cycle, absent HoldIn. Cycle n+1: write-back micro-op, if any.
- StallF/StallD deassert in the cycle the last micro-op issues, so the next instruction enters decode on the following edge. There, the FSM is already IDLE and does not retrigger.
- Total sequence length: n or n+1 issue cycles plus 1 start cycle, plus one extra cycle per HoldIn cycle.
- Micro-op outputs are combinational from registered state only; no input-to-Uop path except HoldIn/Kill gating UopValid.
- Reset mid-sequence: IDLE on the next edge, with all outputs at reset values.

## Structure
- Package ldm_stm_pkg holds:
  - the state encoding (IDLE, XFER, WBACK);
  - field-position constants for P/U/W/L/Rn/list;
  - the constant WORD_BYTES=4;
  - a popcount16 function.
- Sub-module reglist_pe: 16-bit lowest-set-bit priority encoder producing a 4-bit index, a valid flag, and a last-bit flag.

## Test plan
- LDMIA r0,{r1,r2,r3} (W=0): StallF/D=1 in cycles 0–2. Micro-ops in cycles 1–3 with Rd=1,2,3, offsets 0,4,8, UopLoad=1. No WB micro-op; Busy=0 at cycle 4.
- STMDB r13!,{r4,r14} (list 0x4010): Rd=4 offset −8, then Rd=14 offset −4, UopLoad=0. Cycle 3: UopWB=1, Rd=13, offset −8.
- LDMIB r2!,{r2,r5}: offsets 4 and 8. WB suppressed because the base is in the list; IDLE after cycle 2.
- LDMIA r7,{r0..r3} with HoldIn=1 in cycle 2: UopValid=0 in cycle 2. Rd=1 is reissued in cycle 3; the last micro-op (Rd=3) lands in cycle 5.
- Kill in cycle 2 of a 4-register sequence: one micro-op issued (Rd = first bit), none afterwards, IDLE at cycle 3. Reset asserted mid-sequence also gives IDLE with all outputs 0.
- Empty list with BlockValidD=1: no stall, no micro-op, Busy stays 0.

Source files
------------

// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
//   - state_t      : sequencer FSM encoding (IDLE, XFER, WBACK)
//   - BIT_*/RN_*/LIST_* : field positions inside the decode-stage instruction
//   - WORD_BYTES   : byte stride between consecutive transferred registers
//   - popcount16   : number of set bits in a 16-bit register list
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_WBACK = 2'd2
    } state_t;

    localparam int BIT_P   = 24;
    localparam int BIT_U   = 23;
    localparam int BIT_W   = 21;
    localparam int BIT_L   = 20;
    localparam int RN_HI   = 19;
    localparam int RN_LO   = 16;
    localparam int LIST_HI = 15;
    localparam int LIST_LO = 0;

    localparam int WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/reglist_pe.sv
// Lowest-set-bit priority encoder for a 16-bit register list.
//   mask  : remaining register list
//   index : position of the lowest set bit (0 when mask is empty)
//   valid : mask has at least one bit set
//   last  : exactly one bit is set, i.e. this is the final transfer
module reglist_pe (
    input  logic [15:0] mask,
    output logic [3:0]  index,
    output logic        valid,
    output logic        last
);

    // seen[i] = some bit below position i is set; acc folds the one-hot
    // winner's index into a running OR so no loop-carried comb logic is needed.
    logic [16:0] seen;
    logic [3:0]  acc [0:16];

    assign seen[0] = 1'b0;
    assign acc[0]  = 4'd0;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pe
        assign seen[gi+1] = seen[gi] | mask[gi];
        assign acc[gi+1]  = acc[gi] | ((mask[gi] & ~seen[gi]) ? 4'(gi) : 4'd0);
    end

    assign index = acc[16];
    assign valid = seen[16];
    // Clearing the lowest set bit leaves nothing when only one bit remains.
    assign last  = valid & ((mask & (mask - 16'd1)) == 16'd0);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer.
// Freezes fetch/decode while a block transfer in decode is broken into
// single-register load/store micro-ops, optionally followed by a base
// write-back micro-op.
//   clk, reset          : clock, synchronous active-high reset
//   InstrD, BlockValidD : decode-stage instruction and its block-transfer valid
//   HoldIn              : external stall, freezes the sequence
//   Kill                : abort the sequence
//   StallF, StallD      : hold PC and Fetch->Decode registers
//   Busy                : FSM not idle
//   Uop*                : micro-op presented to execute this cycle
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int OFFSET_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         InstrD,
    input  logic                BlockValidD,
    input  logic                HoldIn,
    input  logic                Kill,
    output logic                StallF,
    output logic                StallD,
    output logic                Busy,
    output logic                UopValid,
    output logic                UopLoad,
    output logic                UopWB,
    output logic [3:0]          UopRd,
    output logic [3:0]          UopRn,
    output logic [OFFSET_W-1:0] UopOffset
);

    state_t              state_reg;
    logic [15:0]         mask_reg;
    logic [4:0]          k_reg;
    logic [3:0]          rn_reg;
    logic                load_reg;
    logic                wb_pending_reg;
    logic [OFFSET_W-1:0] base_reg;
    logic [OFFSET_W-1:0] wb_offset_reg;

    logic                unused_instr;
    assign unused_instr = ^{InstrD[31:25], InstrD[22]};

    // Decode-side fields and start-time offset arithmetic.
    logic [15:0]         list_d;
    logic [3:0]          rn_d;
    logic                start;
    logic                wb_needed;
    logic [OFFSET_W-1:0] n_bytes;
    logic [OFFSET_W-1:0] base_start;
    logic [OFFSET_W-1:0] wb_start;

    always_comb begin
        list_d    = InstrD[LIST_HI:LIST_LO];
        rn_d      = InstrD[RN_HI:RN_LO];
        start     = (state_reg == ST_IDLE) & BlockValidD & ~HoldIn & ~Kill
                    & ~reset & (list_d != 16'd0);
        n_bytes   = OFFSET_W'(popcount16(list_d)) * OFFSET_W'(WORD_BYTES);
        if (InstrD[BIT_U]) begin
            base_start = InstrD[BIT_P] ? OFFSET_W'(WORD_BYTES) : '0;
            wb_start   = n_bytes;
        end else begin
            base_start = InstrD[BIT_P] ? -n_bytes : OFFSET_W'(WORD_BYTES) - n_bytes;
            wb_start   = -n_bytes;
        end
        // A loaded base overrides the write-back value, so drop the WB op.
        wb_needed = InstrD[BIT_W] & ~(InstrD[BIT_L] & list_d[rn_d]);
    end

    logic [3:0] pe_index;
    logic       pe_valid;
    logic       pe_last;

    reglist_pe u_pe (
        .mask  (mask_reg),
        .index (pe_index),
        .valid (pe_valid),
        .last  (pe_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            mask_reg       <= '0;
            k_reg          <= '0;
            rn_reg         <= '0;
            load_reg       <= 1'b0;
            wb_pending_reg <= 1'b0;
            base_reg       <= '0;
            wb_offset_reg  <= '0;
        end else if (Kill) begin
            state_reg <= ST_IDLE;
            mask_reg  <= '0;
            k_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_XFER;
                        mask_reg       <= list_d;
                        k_reg          <= '0;
                        rn_reg         <= rn_d;
                        load_reg       <= InstrD[BIT_L];
                        wb_pending_reg <= wb_needed;
                        base_reg       <= base_start;
                        wb_offset_reg  <= wb_start;
                    end
                end
                ST_XFER: begin
                    if (!HoldIn) begin
                        mask_reg <= mask_reg & (mask_reg - 16'd1);
                        k_reg    <= k_reg + 5'd1;
                        if (pe_last || !pe_valid) begin
                            state_reg <= wb_pending_reg ? ST_WBACK : ST_IDLE;
                        end
                    end
                end
                ST_WBACK: begin
                    if (!HoldIn) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Outputs come from registered state; inputs only gate UopValid/stalls.
    logic advance;
    logic last_issue;

    always_comb begin
        advance    = ~HoldIn & ~Kill;
        last_issue = ((state_reg == ST_XFER) & pe_last & ~wb_pending_reg)
                     | (state_reg == ST_WBACK);
        Busy       = (state_reg != ST_IDLE);
        // Release the front end in the final issue cycle so the next
        // instruction enters decode as the FSM returns to IDLE.
        StallF     = start | (Busy & ~Kill & ~(advance & last_issue));
        StallD     = StallF;
        UopValid   = 1'b0;
        UopLoad    = 1'b0;
        UopWB      = 1'b0;
        UopRd      = '0;
        UopRn      = '0;
        UopOffset  = '0;
        case (state_reg)
            ST_XFER: begin
                UopValid  = advance;
                UopLoad   = load_reg;
                UopRd     = pe_index;
                UopRn     = rn_reg;
                UopOffset = base_reg + OFFSET_W'(k_reg) * OFFSET_W'(WORD_BYTES);
            end
            ST_WBACK: begin
                UopValid  = advance;
                UopLoad   = load_reg;
                UopWB     = 1'b1;
                UopRd     = rn_reg;
                UopRn     = rn_reg;
                UopOffset = wb_offset_reg;
            end
            default: ;
        endcase
    end

endmodule
